aes_key_sched_ctrl: RTL

Sequencer for the AES round-key generator. It accepts a cipher key and key-size mode over a start handshake and owns the working-key register feeding `aes_roundkey_gen`. It steps the round index from 0 to Nr and streams one 128-bit round key per accepted handshake to the cipher round datapath.

---
 rtl/aes_pkg.sv | 65 ++++++
 rtl/aes_roundkey_gen.sv | 68 ++++++
 rtl/aes_key_sched_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions for the key-schedule controller and round-key generator.
// Provides the key-size mode encodings, round counts (Nr), the controller FSM state type,
// the forward S-box table, and the word-level helpers used by the key expansion.
package aes_pkg;

  localparam logic [1:0] AES_MODE_128 = 2'b00;
  localparam logic [1:0] AES_MODE_256 = 2'b10;

  localparam logic [3:0] AES_NR_128 = 4'd10;
  localparam logic [3:0] AES_NR_256 = 4'd14;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } aes_ks_state_e;

  localparam logic [7:0] AES_SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // SubWord: byte-wise S-box substitution of a 32-bit word.
  function automatic logic [31:0] aes_sub_word(input logic [31:0] w);
    return {AES_SBOX[w[31:24]], AES_SBOX[w[23:16]], AES_SBOX[w[15:8]], AES_SBOX[w[7:0]]};
  endfunction

  // RotWord: cyclic left rotation by one byte, {a0,a1,a2,a3} -> {a1,a2,a3,a0}.
  function automatic logic [31:0] aes_rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  // Round constant for expansion step idx (1-based). Out-of-range indices give zero.
  function automatic logic [7:0] aes_rcon(input logic [3:0] idx);
    logic [7:0] rc;
    case (idx)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

endpackage

// File: rtl/aes_roundkey_gen.sv
// Combinational AES round-key generator.
// Ports:
//   mode      - in  [1:0]   key-size mode (AES_MODE_128 / AES_MODE_256)
//   key_in    - in  [255:0] working key held by the controller
//   round     - in  [3:0]   round index of the key to produce
//   round_key - out [127:0] round key for 'round'
// For AES-128, key_in[127:0] is the previous round key (the cipher key at round 0/1).
// For AES-256, key_in holds the two most recent 128-bit keys, older in [255:128].
module aes_roundkey_gen
  import aes_pkg::*;
(
  input  logic [1:0]   mode,
  input  logic [255:0] key_in,
  input  logic [3:0]   round,
  output logic [127:0] round_key
);

  logic         is_256;
  logic [127:0] base_key;
  logic [31:0]  base_w [4];
  logic [31:0]  last_word;
  logic [31:0]  sub_in;
  logic [7:0]   rcon_byte;
  logic [31:0]  temp_word;
  logic [127:0] next_key;

  assign is_256 = (mode == AES_MODE_256);

  // The key whose words are XORed forward: previous key (AES-128) or the key two rounds back (AES-256).
  assign base_key = is_256 ? key_in[255:128] : key_in[127:0];

  // The last word of the most recent key sits at key_in[31:0] in both modes.
  assign last_word = key_in[31:0];

  // AES-256 odd rounds use SubWord only (no rotation, no round constant).
  assign sub_in    = (is_256 && round[0]) ? last_word : aes_rot_word(last_word);
  assign rcon_byte = is_256 ? (round[0] ? 8'h00 : aes_rcon({1'b0, round[3:1]})) : aes_rcon(round);
  assign temp_word = aes_sub_word(sub_in) ^ {rcon_byte, 24'h000000};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_base_word
      assign base_w[gi] = base_key[127-32*gi -: 32];
    end
  endgenerate

  // Each new word is temp XOR the prefix-XOR of the base words.
  always_comb begin
    logic [31:0] acc;
    acc      = temp_word;
    next_key = '0;
    for (int i = 0; i < 4; i++) begin
      acc = acc ^ base_w[i];
      next_key[127-32*i -: 32] = acc;
    end
  end

  // Leading rounds are the cipher key itself rather than an expansion step.
  always_comb begin
    round_key = next_key;
    if (round == 4'd0) begin
      round_key = is_256 ? key_in[255:128] : key_in[127:0];
    end else if (is_256 && (round == 4'd1)) begin
      round_key = key_in[127:0];
    end
  end

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES key-schedule sequencer.
// Accepts a cipher key and mode over a start handshake, owns the working-key register
// feeding aes_roundkey_gen, and streams round keys 0..Nr over a valid/ready handshake.
// Ports:
//   clk, reset          - clock (rising edge), asynchronous active-high reset
//   start_valid/ready   - request handshake; ready only while idle
//   mode [1:0]          - 00 AES-128, 10 AES-256, others rejected with mode_err
//   key_in [255:0]      - cipher key (AES-128 uses [127:0])
//   rk_valid/rk_ready   - round-key handshake
//   round_key [127:0]   - current round key
//   rk_round [3:0]      - index of round_key
//   rk_last             - current key is round Nr
//   busy                - request in progress
//   mode_err            - one-cycle pulse after an unsupported request
module aes_key_sched_ctrl
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         start_valid,
  output logic         start_ready,
  input  logic [1:0]   mode,
  input  logic [255:0] key_in,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] round_key,
  output logic [3:0]   rk_round,
  output logic         rk_last,
  output logic         busy,
  output logic         mode_err
);

  aes_ks_state_e state_reg, state_next;
  logic [1:0]    mode_reg, mode_next;
  logic [3:0]    nr_reg, nr_next;
  logic [3:0]    round_cnt_reg, round_cnt_next;
  logic [255:0]  work_key_reg, work_key_next;
  logic          mode_err_reg, mode_err_next;
  logic          mode_ok;
  logic          at_last;

  aes_roundkey_gen u_roundkey_gen (
    .mode      (mode_reg),
    .key_in    (work_key_reg),
    .round     (round_cnt_reg),
    .round_key (round_key)
  );

  assign mode_ok = (mode == AES_MODE_128) || (mode == AES_MODE_256);
  assign at_last = (round_cnt_reg == nr_reg);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_reg      <= AES_MODE_128;
      nr_reg        <= AES_NR_128;
      round_cnt_reg <= 4'd0;
      work_key_reg  <= '0;
      mode_err_reg  <= 1'b0;
    end else begin
      mode_reg      <= mode_next;
      nr_reg        <= nr_next;
      round_cnt_reg <= round_cnt_next;
      work_key_reg  <= work_key_next;
      mode_err_reg  <= mode_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    mode_next      = mode_reg;
    nr_next        = nr_reg;
    round_cnt_next = round_cnt_reg;
    work_key_next  = work_key_reg;
    mode_err_next  = 1'b0;
    start_ready    = 1'b0;
    rk_valid       = 1'b0;
    busy           = 1'b0;
    rk_last        = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        start_ready = 1'b1;
        if (start_valid) begin
          if (mode_ok) begin
            state_next     = ST_EMIT;
            mode_next      = mode;
            nr_next        = (mode == AES_MODE_256) ? AES_NR_256 : AES_NR_128;
            round_cnt_next = 4'd0;
            work_key_next  = key_in;
          end else begin
            mode_err_next = 1'b1;
          end
        end
      end

      ST_EMIT: begin
        rk_valid = 1'b1;
        busy     = 1'b1;
        rk_last  = at_last;
        if (rk_ready) begin
          // Terminal compare comes before the increment, so the counter never passes Nr.
          if (at_last) begin
            state_next = ST_IDLE;
          end else begin
            round_cnt_next = round_cnt_reg + 4'd1;
            if ((mode_reg == AES_MODE_128) && (round_cnt_reg >= 4'd1)) begin
              work_key_next[127:0] = round_key;
            end else if ((mode_reg == AES_MODE_256) && (round_cnt_reg >= 4'd2)) begin
              work_key_next = {work_key_reg[127:0], round_key};
            end
          end
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  assign rk_round = round_cnt_reg;
  assign mode_err = mode_err_reg;

endmodule
